// File: rtl/risc_pack.sv
// risc_pack: shared Qrisc32 decode types, instruction field positions and helpers.
// Contents: opcode constants, incr_code_t, pipe_struct_t, decode_incr(), sext15().
package risc_pack;

    // Instruction field positions (LSB of each field)
    localparam int OP_LSB     = 28;
    localparam int TYPE_LSB   = 26;
    localparam int OFFSEL_BIT = 25;
    localparam int INCR_LSB   = 22;
    localparam int SRC2_LSB   = 10;
    localparam int SRC1_LSB   = 5;
    localparam int DST_LSB    = 0;

    localparam logic [3:0] OP_LDR    = 4'd0;
    localparam logic [3:0] OP_STR    = 4'd1;
    localparam logic [3:0] OP_JMPUNC = 4'd2;
    localparam logic [3:0] OP_JMPF   = 4'd3;
    localparam logic [3:0] OP_ALU    = 4'd4;
    localparam logic [3:0] OP_LDRF   = 4'd5;

    typedef enum logic [2:0] {
        INCR_Z0, INCR_P1, INCR_P2, INCR_P4,
        INCR_Z1, INCR_M1, INCR_M2, INCR_M4
    } incr_code_t;

    typedef struct packed {
        logic        read_mem;
        logic        write_mem;
        logic        write_reg;
        logic        jmpunc;
        logic        jmpz;
        logic        jmpnz;
        logic        jmpc;
        logic        jmpnc;
        logic        and_op;
        logic        or_op;
        logic        xor_op;
        logic        add_op;
        logic        mul_op;
        logic        shl_op;
        logic        shr_op;
        logic        cmp_op;
        logic        ldrf_op;
        logic        incr_r2_enable;
        logic [3:0]  incr_r2;
        logic [4:0]  src1_r;
        logic [4:0]  src2_r;
        logic [4:0]  dst_r;
        logic [31:0] val_r1;
        logic [31:0] val_r2;
        logic [31:0] val_dst;
    } pipe_struct_t;

    // Low two bits give magnitude 0/1/2/4, top bit negates (4-bit two's complement)
    function automatic logic [3:0] decode_incr(input incr_code_t c);
        logic [3:0] m;
        m = (c[1:0] == 2'd3) ? 4'd4 : {2'b00, c[1:0]};
        return c[2] ? -m : m;
    endfunction

    function automatic logic [31:0] sext15(input logic [14:0] v);
        return {{17{v[14]}}, v};
    endfunction

endpackage

// File: rtl/risc_decode_fields.sv
// risc_decode_fields: combinational decode of one instruction word into pipe_struct_t.
// Ports: code (instruction), pc, r1/r2/rd (src1/src2/dst register values) -> pipe.
module risc_decode_fields
    import risc_pack::*;
(
    input  logic [31:0]  code,
    input  logic [31:0]  pc,
    input  logic [31:0]  r1,
    input  logic [31:0]  r2,
    input  logic [31:0]  rd,
    output pipe_struct_t pipe
);
    logic [3:0]  op;
    logic [1:0]  ty;
    logic [31:0] offset;
    logic [3:0]  incr;

    assign op     = code[OP_LSB +: 4];
    assign ty     = code[TYPE_LSB +: 2];
    assign offset = code[OFFSEL_BIT] ? r2 : sext15(code[24:10]);
    assign incr   = decode_incr(incr_code_t'(code[INCR_LSB +: 3]));

    always_comb begin
        pipe = '0;
        pipe.src1_r = code[SRC1_LSB +: 5];
        pipe.src2_r = code[SRC2_LSB +: 5];
        pipe.dst_r  = code[DST_LSB +: 5];
        pipe.incr_r2 = incr;
        pipe.incr_r2_enable = (incr != 4'd0) && (code[OFFSEL_BIT] || op == OP_ALU || op == OP_LDRF);
        case (op)
            OP_LDR: begin
                pipe.write_reg = 1'b1;
                case (ty)
                    2'd1: pipe.val_r1 = {code[20:5], rd[15:0]};
                    2'd2: pipe.val_r1 = {rd[31:16], code[20:5]};
                    2'd3: begin
                        pipe.read_mem = 1'b1;
                        pipe.val_r1   = r1;
                        pipe.val_r2   = offset;
                    end
                    default: pipe.val_r1 = r1;
                endcase
            end
            OP_STR: begin
                if (ty == 2'd3) begin
                    pipe.write_mem = 1'b1;
                    pipe.val_r1    = r1;
                    pipe.val_r2    = offset;
                    pipe.val_dst   = rd;
                end else begin
                    pipe.incr_r2_enable = 1'b0;
                end
            end
            OP_JMPUNC: begin
                pipe.jmpunc = 1'b1;
                case (ty)
                    2'd0: pipe.val_dst = {pc[31:26], code[25:0]};
                    2'd3: pipe.val_dst = rd;
                    default: begin
                        pipe.val_r1    = pc;
                        pipe.val_r2    = offset;
                        pipe.write_reg = (ty == 2'd2);
                        pipe.val_dst   = (ty == 2'd2) ? pc + 32'd4 : 32'd0;
                    end
                endcase
            end
            OP_JMPF: begin
                {pipe.jmpz, pipe.jmpnz, pipe.jmpc, pipe.jmpnc} = 4'b1000 >> ty;
                pipe.val_r1 = pc;
                pipe.val_r2 = offset;
            end
            OP_ALU: begin
                {pipe.and_op, pipe.or_op, pipe.xor_op, pipe.add_op,
                 pipe.mul_op, pipe.shl_op, pipe.shr_op, pipe.cmp_op} = 8'h80 >> code[27:25];
                pipe.write_reg = (code[27:25] != 3'd7);
                pipe.val_r1    = r1;
                pipe.val_r2    = r2;
            end
            OP_LDRF: begin
                // jmp flag acts as the condition select for execute
                {pipe.jmpz, pipe.jmpnz, pipe.jmpc, pipe.jmpnc} = 4'b1000 >> ty;
                pipe.ldrf_op   = 1'b1;
                pipe.write_reg = 1'b1;
                pipe.val_r1    = r1;
                pipe.val_r2    = r2;
            end
            default: pipe.incr_r2_enable = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_decode.sv
// risc_decode: Qrisc32 decode stage with valid/ready output register, flush and load-use bubble.
// Ports: clk/reset; fetch side in_valid/in_ready/in_code/in_pc; flush; RF read ports
// rf_addr1..3/rf_data1..3; writeback wb_en/wb_addr/wb_data; execute side
// out_valid/out_ready/out_pipe; illegal_op pulse.
// Macro RISC_DECODE_WB_BYPASS_EN: forward wb_data onto RF reads matching wb_addr.
module risc_decode
    import risc_pack::*;
#(
    parameter int RF_AW = 5,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_code,
    input  logic [DW-1:0]    in_pc,
    input  logic             flush,
    output logic [RF_AW-1:0] rf_addr1,
    output logic [RF_AW-1:0] rf_addr2,
    output logic [RF_AW-1:0] rf_addr3,
    input  logic [DW-1:0]    rf_data1,
    input  logic [DW-1:0]    rf_data2,
    input  logic [DW-1:0]    rf_data3,
    input  logic             wb_en,
    input  logic [RF_AW-1:0] wb_addr,
    input  logic [DW-1:0]    wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output pipe_struct_t     out_pipe,
    output logic             illegal_op
);
    logic         valid_q, valid_d, illegal_q, illegal_d, hazard, accept;
    pipe_struct_t pipe_q, pipe_d, dec;
    logic [DW-1:0] r1, r2, rd;

    assign rf_addr1 = in_code[SRC1_LSB +: RF_AW];
    assign rf_addr2 = in_code[SRC2_LSB +: RF_AW];
    assign rf_addr3 = in_code[DST_LSB +: RF_AW];

`ifdef RISC_DECODE_WB_BYPASS_EN
    assign r1 = (wb_en && wb_addr == rf_addr1) ? wb_data : rf_data1;
    assign r2 = (wb_en && wb_addr == rf_addr2) ? wb_data : rf_data2;
    assign rd = (wb_en && wb_addr == rf_addr3) ? wb_data : rf_data3;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_addr, wb_data};
    assign r1 = rf_data1;
    assign r2 = rf_data2;
    assign rd = rf_data3;
`endif

    risc_decode_fields u_fields (
        .code (in_code),
        .pc   (in_pc),
        .r1   (r1),
        .r2   (r2),
        .rd   (rd),
        .pipe (dec)
    );

    // Load-use: the held load's destination is read by the incoming word
    assign hazard = valid_q && pipe_q.read_mem &&
                    (pipe_q.dst_r == rf_addr1 || pipe_q.dst_r == rf_addr2 || pipe_q.dst_r == rf_addr3);
    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // Under a hazard accept is 0, so an advancing output loads the bubble
    always_comb begin
        valid_d   = valid_q;
        pipe_d    = pipe_q;
        illegal_d = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
            pipe_d  = '0;
        end else if (!valid_q || out_ready) begin
            valid_d   = accept;
            pipe_d    = accept ? dec : '0;
            illegal_d = accept && (in_code[OP_LSB +: 4] > OP_LDRF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pipe_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pipe_q    <= pipe_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_pipe   = pipe_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_risc_decode.sv
// tb_risc_decode: scoreboard bench for risc_decode with a spec-level reference model.
module tb_risc_decode;
    import risc_pack::*;

    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
    logic [31:0]  in_code = '0, in_pc = '0, wb_data = '0;
    logic [4:0]   wb_addr = '0;
    logic [4:0]   rf_addr1, rf_addr2, rf_addr3;
    logic [31:0]  rf_data1, rf_data2, rf_data3;
    logic         in_ready, out_valid, illegal_op;
    pipe_struct_t out_pipe;

    logic [31:0]  regs [32];
    logic [3:0]   tbl [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd0, 4'hF, 4'hE, 4'hC};
    pipe_struct_t q[$];
    int           total = 0, bad = 0;
    logic         ill_exp = 1'b0, last_acc = 1'b0;

    always #5 clk = ~clk;

    assign rf_data1 = regs[rf_addr1];
    assign rf_data2 = regs[rf_addr2];
    assign rf_data3 = regs[rf_addr3];

    risc_decode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_pc(in_pc), .flush(flush),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .rf_data3(rf_data3),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pipe(out_pipe),
        .illegal_op(illegal_op)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rv(input logic [4:0] a);
`ifdef RISC_DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return regs[a];
    endfunction

    function automatic pipe_struct_t model(input logic [31:0] c, input logic [31:0] pc);
        pipe_struct_t p;
        int op, ty, alu;
        logic [31:0] a, b, d, off;
        op  = int'(c[31:28]);
        ty  = int'(c[27:26]);
        alu = int'(c[27:25]);
        a   = rv(c[9:5]);
        b   = rv(c[14:10]);
        d   = rv(c[4:0]);
        off = c[25] ? b : {{17{c[24]}}, c[24:10]};
        p = '0;
        p.src1_r = c[9:5];
        p.src2_r = c[14:10];
        p.dst_r  = c[4:0];
        p.incr_r2 = tbl[c[24:22]];
        p.incr_r2_enable = (p.incr_r2 != 0) && (c[25] || op == 4 || op == 5) && op <= 5 && !(op == 1 && ty != 3);
        if (op == 0) begin
            p.write_reg = 1;
            p.val_r1 = ty == 1 ? {c[20:5], d[15:0]} : ty == 2 ? {d[31:16], c[20:5]} : a;
            if (ty == 3) begin p.read_mem = 1; p.val_r2 = off; end
        end
        if (op == 1 && ty == 3) begin
            p.write_mem = 1; p.val_r1 = a; p.val_r2 = off; p.val_dst = d;
        end
        if (op == 2) begin
            p.jmpunc = 1;
            if (ty == 0) p.val_dst = {pc[31:26], c[25:0]};
            if (ty == 1 || ty == 2) begin p.val_r1 = pc; p.val_r2 = off; end
            if (ty == 2) begin p.write_reg = 1; p.val_dst = pc + 4; end
            if (ty == 3) p.val_dst = d;
        end
        if (op == 3 || op == 5) begin
            p.jmpz = (ty == 0); p.jmpnz = (ty == 1); p.jmpc = (ty == 2); p.jmpnc = (ty == 3);
        end
        if (op == 3) begin p.val_r1 = pc; p.val_r2 = off; end
        if (op == 4) begin
            p.and_op = alu == 0; p.or_op = alu == 1; p.xor_op = alu == 2; p.add_op = alu == 3;
            p.mul_op = alu == 4; p.shl_op = alu == 5; p.shr_op = alu == 6; p.cmp_op = alu == 7;
            p.write_reg = alu != 7; p.val_r1 = a; p.val_r2 = b;
        end
        if (op == 5) begin p.ldrf_op = 1; p.write_reg = 1; p.val_r1 = a; p.val_r2 = b; end
        return p;
    endfunction

    // One clock of stimulus; the accepted word's expected decode is pushed
    task automatic cyc(input logic iv, input logic [31:0] c, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rs);
        logic hz, er;
        @(posedge clk);
        #2;
        in_valid = iv; in_code = c; in_pc = pc; out_ready = ordy; flush = fl; reset = rs;
        #1;
        hz = q.size() > 0 && q[0].read_mem &&
             (q[0].dst_r == c[9:5] || q[0].dst_r == c[14:10] || q[0].dst_r == c[4:0]);
        er = (q.size() == 0 || ordy) && !hz && !fl;
        chk("in_ready", in_ready, er);
        last_acc = iv && er && !rs;
        if (last_acc) q.push_back(model(c, pc));
        ill_exp = last_acc && c[31:28] > 4'd5;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compares the presented output with the scoreboard head, then retires it
    initial forever begin
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0 && out_valid) chk("out_pipe", out_pipe, q[0]);
        chk("illegal_op", illegal_op, ill_exp);
        #3;
        if (reset) q.delete();
        else if (q.size() > int'(last_acc) && (flush || out_ready)) void'(q.pop_front());
    end

    initial begin
        logic [31:0] c;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        cyc(1'b1, 32'h46C00823, 32'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("reset_pipe", out_pipe, '0);

        // ADD R3,R1,R2 +4
        cyc(1'b1, 32'h46C00823, 32'h100, 1'b1, 1'b0, 1'b0);
        idle();
        chk("add_op", out_pipe.add_op, 1);
        chk("add_wr", out_pipe.write_reg, 1);
        chk("add_r1", out_pipe.val_r1, 5);
        chk("add_r2", out_pipe.val_r2, 7);
        chk("add_incr", out_pipe.incr_r2, 4);
        chk("add_incr_en", out_pipe.incr_r2_enable, 1);
        chk("add_dst", out_pipe.dst_r, 3);

        // JMP absolute
        cyc(1'b1, 32'h20000100, 32'h80000010, 1'b1, 1'b0, 1'b0);
        idle();
        chk("jmp_unc", out_pipe.jmpunc, 1);
        chk("jmp_dst", out_pipe.val_dst, 32'h80000100);

        // Load-use bubble: LDRP R4,[R1+R0] then ADD R5,R4,R2
        cyc(1'b1, 32'h0E000024, 32'h200, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h46000885, 32'h204, 1'b1, 1'b0, 1'b0);
        chk("bubble_rdy", in_ready, 0);
        cyc(1'b1, 32'h46000885, 32'h204, 1'b1, 1'b0, 1'b0);
        chk("bubble_valid", out_valid, 0);
        chk("bubble_acc", in_ready, 1);
        idle();
        chk("after_bubble_add", out_pipe.add_op, 1);
        chk("after_bubble_dst", out_pipe.dst_r, 5);

        // Stall three cycles, then drain
        cyc(1'b1, 32'h46C00823, 32'h300, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 32'h40000C41, 32'h304, 1'b0, 1'b0, 1'b0);
        chk("stall_pipe_add", out_pipe.add_op, 1);
        cyc(1'b1, 32'h40000C41, 32'h304, 1'b1, 1'b0, 1'b0);
        idle();
        chk("stall_next_and", out_pipe.and_op, 1);

        // Flush while valid
        cyc(1'b1, 32'h46C00823, 32'h400, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h40000C41, 32'h404, 1'b1, 1'b1, 1'b0);
        chk("flush_rdy", in_ready, 0);
        idle();
        chk("flush_valid", out_valid, 0);

        // Illegal opcode with register offset and nonzero increment
        cyc(1'b1, 32'hF2C00823, 32'h500, 1'b1, 1'b0, 1'b0);
        idle();
        chk("illegal_pulse", illegal_op, 1);
        chk("illegal_incr_en", out_pipe.incr_r2_enable, 0);
        idle();
        chk("illegal_end", illegal_op, 0);

        // Reset mid-stream drops the held word
        cyc(1'b1, 32'h46C00823, 32'h600, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h40000C41, 32'h604, 1'b0, 1'b0, 1'b1);
        idle();
        chk("reset_drop", out_valid, 0);

`ifdef RISC_DECODE_WB_BYPASS_EN
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hA5;
        cyc(1'b1, 32'h46C00823, 32'h700, 1'b1, 1'b0, 1'b0);
        wb_en = 1'b0;
        idle();
        chk("bypass_r1", out_pipe.val_r1, 32'hA5);
`endif

        for (int n = 0; n < 800; n++) begin
            c = $urandom;
            c[31:28] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
            c[14:10] = 5'($urandom_range(0, 7));
            c[9:5]   = 5'($urandom_range(0, 7));
            c[4:0]   = 5'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 3) != 0), c, $urandom, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 99) == 0));
        end
        idle();
        idle();
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
